sar_adc_ctrl: RTL and testbench

Parametrised digital controller for a multi-channel successive-approximation A/D converter. It synchronises the start request and the per-channel comparator outputs, drives the analog front end's sample/hold, runs the binary-search SAR algorithm on all channels in lock-step, and presents registered results with a completion flag. It sits between the digital core and the analog comparator/DAC macro, replacing the fixed two-channel, 12-bit, 128-cycle controller.

---
 rtl/sar_adc_pkg.sv | 25 ++
 rtl/sar_ch.sv | 54 +++++
 rtl/sar_adc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared types and constants for the SAR ADC controller
// Purpose: FSM state encoding, cycle-counter sizing helper and default
//          parameter values used by sar_adc_ctrl and sar_ch.
// Ports:   none (package).
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CONV   = 2'd2
  } sar_state_e;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_RES      = 12;
  localparam int DEF_SMPL_CYC = 128;
  localparam int DEF_BIT_CYC  = 128;

  // One counter serves both phases, so it is sized for the longer one.
  function automatic int cnt_width(input int smpl_cyc, input int bit_cyc);
    int longest;
    longest = (smpl_cyc > bit_cyc) ? smpl_cyc : bit_cyc;
    return ($clog2(longest) < 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/sar_ch.sv
// rtl/sar_ch.sv - one SAR channel: trial code, bit decision and result register
// Purpose: holds the DAC trial code of a single channel and applies the
//          binary-search decision on the shared strobes from the controller.
// Ports:   clk, rst_n   clock, async active-low reset
//          gt           synchronised comparator output of this channel
//          mask         one-hot bit currently under trial
//          load         start of conversion: code <= MSB only
//          shift        decision edge: resolve masked bit, try next-lower bit
//          publish      final decision edge: copy resolved code to result
//          dac_code     trial code to the DAC
//          result       last completed conversion of this channel
module sar_ch
  import sar_adc_pkg::*;
#(
  parameter int RES = DEF_RES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           gt,
  input  logic [RES-1:0] mask,
  input  logic           load,
  input  logic           shift,
  input  logic           publish,
  output logic [RES-1:0] dac_code,
  output logic [RES-1:0] result
);

  localparam logic [RES-1:0] MSB = RES'(1) << (RES - 1);

  // Trial bit is dropped when the DAC overshoots the held input.
  logic [RES-1:0] decided;

  always_comb begin
    decided = gt ? (dac_code & ~mask) : dac_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_code <= '0;
      result   <= '0;
    end else begin
      if (load) begin
        dac_code <= MSB;
      end else if (shift) begin
        // mask >> 1 is zero on the LSB decision, leaving the final code.
        dac_code <= decided | (mask >> 1);
      end
      if (publish) begin
        result <= decided;
      end
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - multi-channel lock-step SAR ADC controller
// Purpose: synchronises start and comparator inputs, sequences sample and
//          bit-decision phases, and publishes registered results.
//          Optional continuous mode guarded by macro SAR_CONT_EN.
// Ports:   clk, rst_n   clock, async active-low reset
//          strt_cnv     level start request (edge triggered after sync)
//          gt           per-channel comparator outputs
//          cont         (SAR_CONT_EN only) restart sampling on completion
//          smpl         sample/hold enable
//          dac_code     per-channel trial codes, channel i at [i*RES +: RES]
//          result       last completed conversion, same packing
//          busy         start acceptance through final bit decision
//          cnv_cmplt    result valid flag
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int RES      = DEF_RES,
  parameter int SMPL_CYC = DEF_SMPL_CYC,
  parameter int BIT_CYC  = DEF_BIT_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  strt_cnv,
  input  logic [NUM_CH-1:0]     gt,
`ifdef SAR_CONT_EN
  input  logic                  cont,
`endif
  output logic                  smpl,
  output logic [NUM_CH*RES-1:0] dac_code,
  output logic [NUM_CH*RES-1:0] result,
  output logic                  busy,
  output logic                  cnv_cmplt
);

  localparam int             CW        = cnt_width(SMPL_CYC, BIT_CYC);
  localparam logic [CW-1:0]  SMPL_LAST = CW'(SMPL_CYC - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [RES-1:0] MSB       = RES'(1) << (RES - 1);

  sar_state_e        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [RES-1:0]    mask, mask_nxt;
  logic              cmplt_nxt;
  logic              load, shift, publish;
  logic              cont_mode;

  logic              strt_s1, strt_s2, strt_s3;
  logic [NUM_CH-1:0] gt_s1, gt_s2;
  logic              strt_rise;

`ifdef SAR_CONT_EN
  assign cont_mode = cont;
`else
  assign cont_mode = 1'b0;
`endif

  // strt_s3 only feeds the edge detector; control never sees raw inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strt_s1 <= 1'b0;
      strt_s2 <= 1'b0;
      strt_s3 <= 1'b0;
      gt_s1   <= '0;
      gt_s2   <= '0;
    end else begin
      strt_s1 <= strt_cnv;
      strt_s2 <= strt_s1;
      strt_s3 <= strt_s2;
      gt_s1   <= gt;
      gt_s2   <= gt_s1;
    end
  end

  assign strt_rise = strt_s2 & ~strt_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mask      <= '0;
      smpl      <= 1'b0;
      busy      <= 1'b0;
      cnv_cmplt <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mask      <= mask_nxt;
      smpl      <= (state_nxt == SAMPLE);
      busy      <= (state_nxt != IDLE);
      cnv_cmplt <= cmplt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mask_nxt  = mask;
    cmplt_nxt = cnv_cmplt;
    load      = 1'b0;
    shift     = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        // Edges arriving in other states are simply not looked at.
        if (strt_rise) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
          cmplt_nxt = 1'b0;
        end
      end
      SAMPLE: begin
        // Also ends the one-cycle completion pulse of continuous mode.
        cmplt_nxt = 1'b0;
        if (cnt == SMPL_LAST) begin
          cnt_nxt   = '0;
          load      = 1'b1;
          mask_nxt  = MSB;
          state_nxt = CONV;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      CONV: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt  = '0;
          shift    = 1'b1;
          mask_nxt = mask >> 1;
          if (mask[0]) begin
            publish   = 1'b1;
            cmplt_nxt = 1'b1;
            state_nxt = cont_mode ? SAMPLE : IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sar_ch #(
      .RES(RES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .gt       (gt_s2[i]),
      .mask     (mask),
      .load     (load),
      .shift    (shift),
      .publish  (publish),
      .dac_code (dac_code[i*RES +: RES]),
      .result   (result[i*RES +: RES])
    );
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl
// Purpose: two instances (2ch/12b/8/4 and 4ch/8b/8/5) with ideal comparator
//          models; results checked through per-instance scoreboards.
//          Continuous-mode scenario compiled only with SAR_CONT_EN.
// Ports:   none (top-level bench).
module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        strt_a, smpl_a, busy_a, cmplt_a;
  logic [1:0]  gt_a;
  logic [23:0] dac_a, result_a;
  logic        strt_b, smpl_b, busy_b, cmplt_b;
  logic [3:0]  gt_b;
  logic [31:0] dac_b, result_b;
`ifdef SAR_CONT_EN
  logic        cont_a;
`endif

  logic [11:0] vin_a [2];
  logic [7:0]  vin_b [4];
  logic [23:0] exp_a [$];
  logic [31:0] exp_b [$];
  int checks = 0;
  int errors = 0;

  sar_adc_ctrl #(.NUM_CH(2), .RES(12), .SMPL_CYC(8), .BIT_CYC(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_a),
    .gt        (gt_a),
`ifdef SAR_CONT_EN
    .cont      (cont_a),
`endif
    .smpl      (smpl_a),
    .dac_code  (dac_a),
    .result    (result_a),
    .busy      (busy_a),
    .cnv_cmplt (cmplt_a)
  );

  sar_adc_ctrl #(.NUM_CH(4), .RES(8), .SMPL_CYC(8), .BIT_CYC(5)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_b),
    .gt        (gt_b),
`ifdef SAR_CONT_EN
    .cont      (1'b0),
`endif
    .smpl      (smpl_b),
    .dac_code  (dac_b),
    .result    (result_b),
    .busy      (busy_b),
    .cnv_cmplt (cmplt_b)
  );

  for (genvar i = 0; i < 2; i++) begin : g_cmp_a
    assign gt_a[i] = dac_a[i*12 +: 12] > vin_a[i];
  end
  for (genvar i = 0; i < 4; i++) begin : g_cmp_b
    assign gt_b[i] = dac_b[i*8 +: 8] > vin_b[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards: pop on each rising edge of the completion flag.
  logic cmplt_a_q = 1'b0;
  logic cmplt_b_q = 1'b0;
  always @(negedge clk) begin
    if (cmplt_a && !cmplt_a_q) begin
      if (exp_a.size() == 0) check("a_unexpected_done", 32'(exp_a.size()), 32'd1);
      else check("a_result", 32'(result_a), 32'(exp_a.pop_front()));
    end
    if (cmplt_b && !cmplt_b_q) begin
      if (exp_b.size() == 0) check("b_unexpected_done", 32'(exp_b.size()), 32'd1);
      else check("b_result", result_b, exp_b.pop_front());
    end
    cmplt_a_q = cmplt_a;
    cmplt_b_q = cmplt_b;
  end

  // One conversion on instance A. pulse_len 0 keeps strt_cnv high;
  // pulse2_at > 0 adds a 2-cycle request at that cycle.
  task automatic conv_a(input logic [11:0] v0, input logic [11:0] v1,
                        input int pulse_len, input int pulse2_at, input bit chk_dac);
    int n, lat, smpl_n, busy_n, k;
    logic [11:0] e0, e1;
    vin_a[0] = v0;
    vin_a[1] = v1;
    exp_a.push_back({v1, v0});
    @(negedge clk);
    strt_a = 1'b1;
    n = 0; lat = -1; smpl_n = 0; busy_n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == pulse_len) strt_a = 1'b0;
      if (pulse2_at > 0 && n == pulse2_at) strt_a = 1'b1;
      if (pulse2_at > 0 && n == pulse2_at + 2) strt_a = 1'b0;
      if (busy_a && lat < 0) lat = n;
      if (smpl_a) smpl_n++;
      if (busy_a) busy_n++;
      if (chk_dac && n >= 11 && n <= 55 && ((n - 11) % 4) == 0) begin
        k  = (n - 11) / 4;
        e0 = 12'((32'hFFF << (11 - k)) & 32'hFFF);
        e1 = 12'(32'h800 >> k);
        check("a_dac_ch0", 32'(dac_a[11:0]), 32'(e0));
        check("a_dac_ch1", 32'(dac_a[23:12]), 32'(e1));
      end
      if (lat >= 0 && !busy_a) break;
    end
    check("a_start_latency", 32'(lat), 32'd3);
    check("a_smpl_len", 32'(smpl_n), 32'd8);
    check("a_busy_len", 32'(busy_n), 32'd56);
    check("a_done_cycle", 32'(n), 32'd59);
    check("a_cmplt_at_end", 32'(cmplt_a), 32'd1);
  endtask

  initial begin
    int n, busy_n, lat;
    bit hit;
    rst_n  = 1'b0;
    strt_a = 1'b0;
    strt_b = 1'b0;
    vin_a[0] = '0; vin_a[1] = '0;
    for (int c = 0; c < 4; c++) vin_b[c] = '0;
`ifdef SAR_CONT_EN
    cont_a = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_smpl", 32'(smpl_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_cmplt", 32'(cmplt_a), 32'd0);
    check("rst_dac", 32'(dac_a), 32'd0);
    check("rst_result", 32'(result_a), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    conv_a(12'h5A3, 12'h25C, 2, 0, 1'b0);
    repeat (4) @(negedge clk);
    conv_a(12'hFFF, 12'h000, 2, 0, 1'b1);
    repeat (4) @(negedge clk);

    // Level held through completion: exactly one conversion.
    conv_a(12'h123, 12'hABC, 0, 0, 1'b0);
    hit = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a) hit = 1'b1;
    end
    check("a_held_no_retrigger", 32'(hit), 32'd0);
    check("a_held_cmplt_sticky", 32'(cmplt_a), 32'd1);
    strt_a = 1'b0;
    repeat (4) @(negedge clk);

    // Second request during CONV is dropped.
    conv_a(12'h7FF, 12'h800, 2, 30, 1'b0);
    hit = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy_a) hit = 1'b1;
    end
    check("a_ignored_edge", 32'(hit), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    vin_a[0] = 12'h3C3; vin_a[1] = 12'h0F0;
    @(negedge clk);
    strt_a = 1'b1;
    repeat (2) @(negedge clk);
    strt_a = 1'b0;
    repeat (18) @(negedge clk);
    check("a_busy_before_rst", 32'(busy_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("a_arst_smpl", 32'(smpl_a), 32'd0);
    check("a_arst_busy", 32'(busy_a), 32'd0);
    check("a_arst_cmplt", 32'(cmplt_a), 32'd0);
    check("a_arst_dac", 32'(dac_a), 32'd0);
    check("a_arst_result", 32'(result_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    conv_a(12'h001, 12'hFFE, 2, 0, 1'b0);
    repeat (4) @(negedge clk);

`ifdef SAR_CONT_EN
    begin
      int pulses, last;
      bit started, dropped;
      for (int k = 1; k <= 3; k++) exp_a.push_back({12'(12'hFFF - 12'(k * 'h100)), 12'(k * 'h100)});
      vin_a[0] = 12'h100; vin_a[1] = 12'hEFF;
      cont_a = 1'b1;
      @(negedge clk);
      strt_a = 1'b1;
      n = 0; pulses = 0; last = 0; started = 1'b0; dropped = 1'b0;
      while (pulses < 3 && n < 400) begin
        @(negedge clk);
        n++;
        if (n == 2) strt_a = 1'b0;
        if (busy_a) started = 1'b1;
        if (started && !busy_a && pulses < 2) dropped = 1'b1;
        if (cmplt_a) begin
          pulses++;
          if (pulses > 1) check("cont_spacing", 32'(n - last), 32'd56);
          last = n;
          vin_a[0] = 12'((pulses + 1) * 'h100);
          vin_a[1] = 12'hFFF - vin_a[0];
          if (pulses == 2) cont_a = 1'b0;
        end
      end
      check("cont_pulses", 32'(pulses), 32'd3);
      check("cont_busy_held", 32'(dropped), 32'd0);
      @(negedge clk);
      check("cont_final_sticky", 32'(cmplt_a), 32'd1);
      check("cont_final_idle", 32'(busy_a), 32'd0);
      repeat (4) @(negedge clk);
    end
`endif

    // Instance B: random inputs, extremes on the first pass.
    for (int t = 0; t < 100; t++) begin
      for (int c = 0; c < 4; c++) vin_b[c] = 8'($urandom_range(0, 255));
      if (t == 0) begin
        vin_b[0] = 8'hFF; vin_b[1] = 8'h00; vin_b[2] = 8'h80; vin_b[3] = 8'h7F;
      end
      exp_b.push_back({vin_b[3], vin_b[2], vin_b[1], vin_b[0]});
      @(negedge clk);
      strt_b = 1'b1;
      n = 0; lat = -1; busy_n = 0;
      while (n < 200) begin
        @(negedge clk);
        n++;
        if (n == 2) strt_b = 1'b0;
        if (busy_b && lat < 0) lat = n;
        if (busy_b) busy_n++;
        if (lat >= 0 && !busy_b) break;
      end
      check("b_busy_len", 32'(busy_n), 32'd48);
      repeat (2) @(negedge clk);
    end

    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
